// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, issues 1-cycle-latency ROM reads and buffers
// PC-tagged instructions in a first-word-fall-through prefetch FIFO for decode.

module inst_fetch_chk #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 3
) (
   input logic             clk,
   input logic             reset,
   input logic             push,
   input logic [CNT_W-1:0] count,
   input logic             inflight
);
   // Credit accounting must keep every outstanding response landing in a free slot
   always_ff @(posedge clk) begin
      if (reset) begin
         assert (!(push && (int'(count) >= DEPTH)));
         assert ((int'(count) + int'(inflight)) <= DEPTH);
      end
   end
endmodule

module inst_fetch #(
   parameter int                ADDR_W   = 8,
   parameter int                INST_W   = 8,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
   input  logic              clk,
   input  logic              reset,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [INST_W-1:0] mem_rdata,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [INST_W-1:0] inst_out,
   output logic [ADDR_W-1:0] inst_pc,
   output logic [ADDR_W-1:0] fetch_pc
);
   localparam int                PTR_W   = $clog2(DEPTH);
   localparam int                ENT_W   = INST_W + ADDR_W;
   localparam logic [PTR_W:0]    DEPTH_L = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]    CNT_ONE = {{PTR_W{1'b0}}, 1'b1};
   localparam logic [PTR_W-1:0]  PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

   logic [ENT_W-1:0]  fifo_r [DEPTH];
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W:0]    count_r;
   logic              inflight_r;
   logic              squash_r;
   logic [ADDR_W-1:0] tag_pc_r;
   logic [ADDR_W-1:0] fetch_pc_r;
   logic              push_s;
   logic              pop_s;
   logic [PTR_W:0]    occ_s;
   logic [ENT_W-1:0]  head_s;

   // Handshake, credit check and FWFT head presentation
   always_comb begin
      inst_valid = (count_r != {(PTR_W+1){1'b0}});
      pop_s      = inst_valid && inst_ready;
      // a slot freed by this cycle's pop may be re-requested immediately
      occ_s      = count_r + {{PTR_W{1'b0}}, inflight_r} - {{PTR_W{1'b0}}, pop_s};
      mem_req    = reset && !redirect && (occ_s < DEPTH_L);
      push_s     = inflight_r && !squash_r && !redirect;
      head_s     = fifo_r[rd_ptr_r];
      if (inst_valid) begin
         inst_out = head_s[ENT_W-1:ADDR_W];
         inst_pc  = head_s[ADDR_W-1:0];
      end else begin
         inst_out = {INST_W{1'b0}};
         inst_pc  = {ADDR_W{1'b0}};
      end
   end

   assign mem_addr = fetch_pc_r;
   assign fetch_pc = fetch_pc_r;

   // PC, in-flight tracking and FIFO pointer/count control
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc_r <= RESET_PC;
         inflight_r <= 1'b0;
         squash_r   <= 1'b0;
         tag_pc_r   <= {ADDR_W{1'b0}};
         rd_ptr_r   <= {PTR_W{1'b0}};
         wr_ptr_r   <= {PTR_W{1'b0}};
         count_r    <= {(PTR_W+1){1'b0}};
      end else if (redirect) begin
         fetch_pc_r <= redirect_pc;
         inflight_r <= 1'b0;
         squash_r   <= 1'b1;
         rd_ptr_r   <= {PTR_W{1'b0}};
         wr_ptr_r   <= {PTR_W{1'b0}};
         count_r    <= {(PTR_W+1){1'b0}};
      end else begin
         squash_r   <= 1'b0;
         inflight_r <= mem_req;
         tag_pc_r   <= fetch_pc_r;
         if (mem_req) begin
            fetch_pc_r <= fetch_pc_r + PC_ONE;
         end
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage: returned instruction tagged with its request PC
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            fifo_r[i] <= {ENT_W{1'b0}};
         end
      end else if (push_s) begin
         fifo_r[wr_ptr_r] <= {mem_rdata, tag_pc_r};
      end
   end

   inst_fetch_chk #(.DEPTH(DEPTH), .CNT_W(PTR_W+1)) u_chk (
      .clk      (clk),
      .reset    (reset),
      .push     (push_s),
      .count    (count_r),
      .inflight (inflight_r)
   );
endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus random ready/redirect/reset,
// compared against a queue-based reference model of the fetch stage.

module tb_inst_fetch;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       mem_req;
   logic [7:0] mem_addr;
   logic [7:0] mem_rdata = 8'h00;
   logic       redirect = 1'b0;
   logic [7:0] redirect_pc = 8'h00;
   logic       inst_valid;
   logic       inst_ready = 1'b0;
   logic [7:0] inst_out;
   logic [7:0] inst_pc;
   logic [7:0] fetch_pc;

   logic [7:0] rom [256];
   int checks = 0;
   int errors = 0;

   // reference model state: buffered {inst, pc}, outstanding request, next PC
   logic [15:0] q[$];
   bit          pend;
   logic [7:0]  pend_pc;
   logic [7:0]  fpc;

   always #5 clk = ~clk;

   always @(posedge clk) mem_rdata <= rom[mem_addr];

   inst_fetch #(.ADDR_W(8), .INST_W(8), .DEPTH(DEPTH), .RESET_PC(8'h00)) dut (
      .clk         (clk),
      .reset       (reset),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_rdata   (mem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .inst_out    (inst_out),
      .inst_pc     (inst_pc),
      .fetch_pc    (fetch_pc)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Async reset mid-cycle, check reset values at once, release after one edge
   task automatic do_reset();
      reset = 1'b0;
      #1;
      chk("rst_req", {31'd0, mem_req}, 32'd0);
      chk("rst_valid", {31'd0, inst_valid}, 32'd0);
      chk("rst_out", {24'd0, inst_out}, 32'd0);
      chk("rst_pc", {24'd0, inst_pc}, 32'd0);
      chk("rst_fetch_pc", {24'd0, fetch_pc}, 32'd0);
      q.delete();
      pend = 1'b0;
      pend_pc = 8'h00;
      fpc = 8'h00;
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   // One clock cycle: drive inputs, check outputs against model, advance model across the edge
   task automatic cycle(input logic rdy, input logic rd, input logic [7:0] rpc);
      bit         v;
      bit         pop;
      bit         req;
      int         occ;
      logic [7:0] eo;
      logic [7:0] ep;
      logic [15:0] head;
      inst_ready = rdy;
      redirect = rd;
      redirect_pc = rpc;
      #2;
      v = (q.size() > 0);
      head = v ? q[0] : 16'h0000;
      eo = head[15:8];
      ep = head[7:0];
      pop = v && rdy;
      occ = q.size() + int'(pend) - int'(pop);
      req = !rd && (occ < DEPTH);
      chk("inst_valid", {31'd0, inst_valid}, {31'd0, v});
      chk("inst_out", {24'd0, inst_out}, {24'd0, eo});
      chk("inst_pc", {24'd0, inst_pc}, {24'd0, ep});
      chk("mem_req", {31'd0, mem_req}, {31'd0, req});
      chk("fetch_pc", {24'd0, fetch_pc}, {24'd0, fpc});
      if (req) chk("mem_addr", {24'd0, mem_addr}, {24'd0, fpc});
      if (rd) begin
         q.delete();
      end else begin
         if (pop) void'(q.pop_front());
         if (pend) q.push_back({rom[pend_pc], pend_pc});
      end
      pend = req;
      pend_pc = fpc;
      if (rd) fpc = rpc;
      else if (req) fpc = fpc + 8'd1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int a = 0; a < 256; a++) rom[a] = 8'(a) ^ 8'hA5;
      #1;
      do_reset();

      // streaming from reset with decode always ready
      repeat (3) cycle(1'b1, 1'b0, 8'h00);
      chk("t1_out", {24'd0, inst_out}, 32'h0000_00A4);
      chk("t1_pc", {24'd0, inst_pc}, 32'h0000_0001);
      repeat (5) cycle(1'b1, 1'b0, 8'h00);

      // stall fills exactly DEPTH entries, one pop frees one request
      do_reset();
      repeat (6) cycle(1'b0, 1'b0, 8'h00);
      chk("stall_fetch_pc", {24'd0, fetch_pc}, 32'h0000_0004);
      chk("stall_head_pc", {24'd0, inst_pc}, 32'h0000_0000);
      cycle(1'b1, 1'b0, 8'h00);
      chk("stall_pop_pc", {24'd0, inst_pc}, 32'h0000_0001);
      chk("stall_refetch", {24'd0, fetch_pc}, 32'h0000_0005);
      repeat (3) cycle(1'b0, 1'b0, 8'h00);

      // redirect with pcs 5,6 buffered and 7 in flight
      do_reset();
      repeat (7) cycle(1'b1, 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 8'h00);
      chk("redir_pre_head", {24'd0, inst_pc}, 32'h0000_0005);
      cycle(1'b0, 1'b1, 8'h40);
      chk("redir_flush", {31'd0, inst_valid}, 32'd0);
      repeat (2) cycle(1'b1, 1'b0, 8'h00);
      chk("redir_valid", {31'd0, inst_valid}, 32'd1);
      chk("redir_pc40", {24'd0, inst_pc}, 32'h0000_0040);
      repeat (4) cycle(1'b1, 1'b0, 8'h00);

      // PC wrap through 0xFF
      cycle(1'b1, 1'b1, 8'hFE);
      repeat (2) cycle(1'b1, 1'b0, 8'h00);
      chk("wrap_fe", {24'd0, inst_pc}, 32'h0000_00FE);
      cycle(1'b1, 1'b0, 8'h00);
      chk("wrap_ff", {24'd0, inst_pc}, 32'h0000_00FF);
      cycle(1'b1, 1'b0, 8'h00);
      chk("wrap_00", {24'd0, inst_pc}, 32'h0000_0000);
      cycle(1'b1, 1'b0, 8'h00);
      chk("wrap_01", {24'd0, inst_pc}, 32'h0000_0001);

      // back-to-back redirects: last one wins
      cycle(1'b1, 1'b1, 8'h10);
      cycle(1'b1, 1'b1, 8'h20);
      chk("b2b_empty0", {31'd0, inst_valid}, 32'd0);
      cycle(1'b1, 1'b0, 8'h00);
      chk("b2b_empty1", {31'd0, inst_valid}, 32'd0);
      cycle(1'b1, 1'b0, 8'h00);
      chk("b2b_valid", {31'd0, inst_valid}, 32'd1);
      chk("b2b_pc20", {24'd0, inst_pc}, 32'h0000_0020);
      repeat (3) cycle(1'b1, 1'b0, 8'h00);

      // reset with FIFO full, then with a request in flight
      repeat (8) cycle(1'b0, 1'b0, 8'h00);
      chk("full_valid", {31'd0, inst_valid}, 32'd1);
      do_reset();
      repeat (2) cycle(1'b1, 1'b0, 8'h00);
      chk("post_rst_pc", {24'd0, inst_pc}, 32'h0000_0000);
      do_reset();
      repeat (3) cycle(1'b1, 1'b0, 8'h00);

      // random ready / redirect / occasional reset
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 63) == 0) do_reset();
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 8'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
